scnn_cordn_sequencer: RTL

//  Drives the scnn_output_cordn unit across a full weight x input Cartesian product.
//  - Outer loop walks compressed weight chunks; inner loop walks compressed input chunks.
//  - Each chunk is NUM_LANES indices wide.
//  - Fetches the compressed-index chunks and tracks running offsets (dense base index per chunk).
//  - Presents one chunk pair per transaction to the coordinate unit and hands the pair downstream
//    to the accumulator crossbar over a valid/ready link.

---
 rtl/scnn_pkg.sv | 24 ++
 rtl/scnn_cordn_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/scnn_pkg.sv
// Shared types and constants for the SCNN coordinate-unit sequencer.
// Chunk geometry is fixed to the coordinate-unit lane count.
package scnn_pkg;

  localparam int NUM_LANES = 4;
  localparam int IND_W     = 8;
  localparam int CHUNK_W   = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  typedef logic [NUM_LANES-1:0][IND_W-1:0] ind_chunk_t;

  // Dense base of the next chunk: one past the last index, wrapping mod 2^IND_W.
  function automatic logic [IND_W-1:0] next_offset(input logic [IND_W-1:0] last_ind);
    return last_ind + IND_W'(1'b1);
  endfunction

endpackage

// File: rtl/scnn_cordn_sequencer.sv
// Walks the weight x input compressed-chunk Cartesian product, feeding the coordinate
// unit one chunk pair per transaction and handing each pair downstream over valid/ready.
module scnn_cordn_sequencer
  import scnn_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [CHUNK_W-1:0]           num_wt_chunks,
  input  logic [CHUNK_W-1:0]           num_ip_chunks,
  input  logic [3:0]                   wt_size,
  input  logic [IND_W-1:0]             ip_size,
  output logic                         wt_rd_en,
  output logic [CHUNK_W-1:0]           wt_rd_addr,
  input  logic [NUM_LANES*IND_W-1:0]   wt_rd_data,
  output logic                         ip_rd_en,
  output logic [CHUNK_W-1:0]           ip_rd_addr,
  input  logic [NUM_LANES*IND_W-1:0]   ip_rd_data,
  output logic [NUM_LANES*IND_W-1:0]   cu_comp_wt_ind,
  output logic [NUM_LANES*IND_W-1:0]   cu_comp_ip_ind,
  output logic [IND_W-1:0]             cu_offset_wt,
  output logic [IND_W-1:0]             cu_offset_ip,
  output logic [3:0]                   cu_wt_size,
  output logic [IND_W-1:0]             cu_ip_size,
  input  logic [IND_W-1:0]             cu_last_ind_wts,
  input  logic [IND_W-1:0]             cu_last_ind_ips,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [CHUNK_W-1:0]           op_wt_chunk,
  output logic [CHUNK_W-1:0]           op_ip_chunk,
  output logic                         op_last,
  output logic                         busy,
  output logic                         done
);

  seq_state_t           state_r;
  logic                 fetch_wt_r;
  logic [CHUNK_W-1:0]   wt_cnt_r;
  logic [CHUNK_W-1:0]   ip_cnt_r;
  logic [CHUNK_W-1:0]   num_wt_r;
  logic [CHUNK_W-1:0]   num_ip_r;
  logic [IND_W-1:0]     offset_wt_r;
  logic [IND_W-1:0]     offset_ip_r;
  ind_chunk_t           wt_comp_r;
  ind_chunk_t           ip_comp_r;
  logic [3:0]           wt_size_r;
  logic [IND_W-1:0]     ip_size_r;
  logic                 wt_rd_en_r;
  logic                 ip_rd_en_r;
  logic                 op_valid_r;
  logic                 op_last_r;
  logic                 busy_r;
  logic                 done_r;

  logic                 ip_more_s;
  logic                 wt_more_s;
  logic                 handshake_s;

  // Loop-position decode; counts are nonzero whenever these are consulted.
  always_comb begin
    ip_more_s   = (ip_cnt_r < (num_ip_r - CHUNK_W'(1'b1)));
    wt_more_s   = (wt_cnt_r < (num_wt_r - CHUNK_W'(1'b1)));
    handshake_s = op_valid_r && op_ready;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      fetch_wt_r  <= 1'b0;
      wt_cnt_r    <= '0;
      ip_cnt_r    <= '0;
      num_wt_r    <= '0;
      num_ip_r    <= '0;
      offset_wt_r <= '0;
      offset_ip_r <= '0;
      wt_comp_r   <= '0;
      ip_comp_r   <= '0;
      wt_size_r   <= '0;
      ip_size_r   <= '0;
      wt_rd_en_r  <= 1'b0;
      ip_rd_en_r  <= 1'b0;
      op_valid_r  <= 1'b0;
      op_last_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      wt_rd_en_r <= 1'b0;
      ip_rd_en_r <= 1'b0;
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          // busy_r still high here means a done pulse is in flight; hold off a new pass.
          if (start && !busy_r) begin
            num_wt_r    <= num_wt_chunks;
            num_ip_r    <= num_ip_chunks;
            wt_size_r   <= wt_size;
            ip_size_r   <= ip_size;
            offset_wt_r <= '0;
            offset_ip_r <= '0;
            wt_cnt_r    <= '0;
            ip_cnt_r    <= '0;
            fetch_wt_r  <= 1'b1;
            busy_r      <= 1'b1;
            if ((num_wt_chunks == '0) || (num_ip_chunks == '0)) begin
              state_r <= DONE;
            end else begin
              state_r    <= FETCH;
              wt_rd_en_r <= 1'b1;
              ip_rd_en_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        FETCH: begin
          state_r <= WAIT;
        end
        WAIT: begin
          ip_comp_r <= ip_rd_data;
          if (fetch_wt_r) begin
            wt_comp_r <= wt_rd_data;
          end
          op_valid_r <= 1'b1;
          op_last_r  <= !ip_more_s && !wt_more_s;
          state_r    <= ISSUE;
        end
        ISSUE: begin
          if (handshake_s) begin
            op_valid_r <= 1'b0;
            op_last_r  <= 1'b0;
            if (ip_more_s) begin
              offset_ip_r <= next_offset(cu_last_ind_ips);
              ip_cnt_r    <= ip_cnt_r + CHUNK_W'(1'b1);
              fetch_wt_r  <= 1'b0;
              ip_rd_en_r  <= 1'b1;
              state_r     <= FETCH;
            end else if (wt_more_s) begin
              offset_wt_r <= next_offset(cu_last_ind_wts);
              offset_ip_r <= '0;
              ip_cnt_r    <= '0;
              wt_cnt_r    <= wt_cnt_r + CHUNK_W'(1'b1);
              fetch_wt_r  <= 1'b1;
              wt_rd_en_r  <= 1'b1;
              ip_rd_en_r  <= 1'b1;
              state_r     <= FETCH;
            end else begin
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign wt_rd_en       = wt_rd_en_r;
  assign wt_rd_addr     = wt_cnt_r;
  assign ip_rd_en       = ip_rd_en_r;
  assign ip_rd_addr     = ip_cnt_r;
  assign cu_comp_wt_ind = wt_comp_r;
  assign cu_comp_ip_ind = ip_comp_r;
  assign cu_offset_wt   = offset_wt_r;
  assign cu_offset_ip   = offset_ip_r;
  assign cu_wt_size     = wt_size_r;
  assign cu_ip_size     = ip_size_r;
  assign op_valid       = op_valid_r;
  assign op_wt_chunk    = wt_cnt_r;
  assign op_ip_chunk    = ip_cnt_r;
  assign op_last        = op_last_r;
  assign busy           = busy_r;
  assign done           = done_r;

endmodule
